// File: rtl/reg_bus_pkg.sv
// Register-bus initiator shared types: FSM states, register map, bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package reg_bus_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, R_WAIT, DONE
    } state_t;

    typedef enum logic [1:0] {
        SG_IDLE, SG_SETUP, SG_PULSE, SG_HOLD
    } sg_stage_t;

    // Register map of the target register file
    localparam logic [ADDR_W-1:0] REG_DECIM_B0    = 5'h00;
    localparam logic [ADDR_W-1:0] REG_DECIM_B1    = 5'h01;
    localparam logic [ADDR_W-1:0] REG_DECIM_B2    = 5'h02;
    localparam logic [ADDR_W-1:0] REG_TRIG_LVL_A  = 5'h03;
    localparam logic [ADDR_W-1:0] REG_TRIG_LVL_B  = 5'h04;
    localparam logic [ADDR_W-1:0] REG_WINDOW_B0   = 5'h05;
    localparam logic [ADDR_W-1:0] REG_WINDOW_B1   = 5'h06;
    localparam logic [ADDR_W-1:0] REG_WINDOW_B2   = 5'h07;
    localparam logic [ADDR_W-1:0] REG_WINDOW_B3   = 5'h08;
    localparam logic [ADDR_W-1:0] REG_CNF_PIN_A   = 5'h09;
    localparam logic [ADDR_W-1:0] REG_CNF_PIN_B   = 5'h0A;
    localparam logic [ADDR_W-1:0] REG_KEY_INPUT   = 5'h0B;
    localparam logic [ADDR_W-1:0] REG_DELAY       = 5'h0C;
    localparam logic [ADDR_W-1:0] REG_EXT_PIN_LO  = 5'h0D;
    localparam logic [ADDR_W-1:0] REG_EXT_PIN_HI  = 5'h0E;
    localparam logic [ADDR_W-1:0] REG_WRITE_CTRL  = 5'h0F;
    localparam logic [ADDR_W-1:0] REG_SRAM_DATA   = 5'h10;

endpackage

// File: rtl/bus_strobe_gen.sv
// One SETUP/PULSE/HOLD strobe phase launched by a start pulse; registered BUS_WRITE.
// Latency: SETUP_W+PULSE_W+HOLD_W cycles from start to the end of HOLD.
// Backpressure: none; a start during HOLD's last cycle chains straight into the next phase.
`timescale 1ns/1ps
module bus_strobe_gen
    import reg_bus_pkg::*;
#(
    parameter int SETUP_W = 1,
    parameter int PULSE_W = 2,
    parameter int HOLD_W  = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic start,
    output logic bus_write,
    output logic stage_last,
    output logic done
);

    sg_stage_t          stage_q, stage_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bw_d;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        bw_d    = bus_write;
        if (start) begin
            stage_d = SG_SETUP;
            cnt_d   = CNT_W'(SETUP_W - 1);
            bw_d    = 1'b0;
        end else if (stage_q != SG_IDLE) begin
            if (cnt_q == '0) begin
                case (stage_q)
                    SG_SETUP: begin
                        stage_d = SG_PULSE;
                        cnt_d   = CNT_W'(PULSE_W - 1);
                        bw_d    = 1'b1;
                    end
                    SG_PULSE: begin
                        stage_d = SG_HOLD;
                        cnt_d   = CNT_W'(HOLD_W - 1);
                        bw_d    = 1'b0;
                    end
                    default: begin
                        stage_d = SG_IDLE;
                        cnt_d   = '0;
                        bw_d    = 1'b0;
                    end
                endcase
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage_q   <= SG_IDLE;
            cnt_q     <= '0;
            bus_write <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            bus_write <= bw_d;
        end
    end

    assign stage_last = (stage_q != SG_IDLE) && (cnt_q == '0);
    assign done       = (stage_q == SG_HOLD) && (cnt_q == '0);

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus initiator: single-beat commands to address/data strobe phases. Option: REG_BUS_ADDR_CACHE_EN.
// Latency: write 2*(S+P+H)+1, read S+P+H+READ_WAIT+1 cycles from acceptance to RSP_VALID.
// Backpressure: CMD_READY only in IDLE; one command in flight, CMD_VALID ignored while BUSY.
`timescale 1ns/1ps
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int SETUP_W   = 1,
    parameter int PULSE_W   = 2,
    parameter int HOLD_W    = 1,
    parameter int READ_WAIT = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              BUS_ADDR_OR_DATA,
    output logic              BUS_WRITE,
    output logic [DATA_W-1:0] BUS_DATA_OUT,
    input  logic [DATA_W-1:0] BUS_DATA_IN,
    output logic              BUSY
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q, cur_addr;
    logic [DATA_W-1:0]  data_q, cur_data;
    logic               sg_start, sg_last, sg_done;
    logic               addr_hit;

`ifdef REG_BUS_ADDR_CACHE_EN
    logic [ADDR_W-1:0]  cache_addr_q;
    logic               cache_vld_q;

    assign addr_hit = cache_vld_q && (cache_addr_q == CMD_ADDR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cache_addr_q <= '0;
            cache_vld_q  <= 1'b0;
        end else if (state_q == A_HOLD && sg_done) begin
            cache_addr_q <= addr_q;
            cache_vld_q  <= 1'b1;
        end
    end
`else
    assign addr_hit = 1'b0;
`endif

    // In IDLE the command is not latched yet, so phase entry looks at the live inputs
    assign cur_addr = (state_q == IDLE) ? CMD_ADDR : addr_q;
    assign cur_data = (state_q == IDLE) ? CMD_DATA : data_q;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        sg_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    if (addr_hit && CMD_WRITE) begin
                        state_d  = D_SETUP;
                        sg_start = 1'b1;
                    end else if (addr_hit) begin
                        state_d  = R_WAIT;
                        rd_cnt_d = CNT_W'(READ_WAIT - 1);
                    end else begin
                        state_d  = A_SETUP;
                        sg_start = 1'b1;
                    end
                end
            end
            A_SETUP: if (sg_last) state_d = A_PULSE;
            A_PULSE: if (sg_last) state_d = A_HOLD;
            A_HOLD: begin
                if (sg_done) begin
                    if (wr_q) begin
                        state_d  = D_SETUP;
                        sg_start = 1'b1;
                    end else begin
                        state_d  = R_WAIT;
                        rd_cnt_d = CNT_W'(READ_WAIT - 1);
                    end
                end
            end
            D_SETUP: if (sg_last) state_d = D_PULSE;
            D_PULSE: if (sg_last) state_d = D_HOLD;
            D_HOLD:  if (sg_done) state_d = DONE;
            R_WAIT: begin
                if (rd_cnt_q == '0) state_d = DONE;
                else                rd_cnt_d = rd_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Select/data only move on phase entry, while BUS_WRITE is already low
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_q             <= 1'b0;
            addr_q           <= '0;
            data_q           <= '0;
            BUS_ADDR_OR_DATA <= 1'b0;
            BUS_DATA_OUT     <= '0;
            RSP_DATA         <= '0;
        end else begin
            if (state_q == IDLE && CMD_VALID) begin
                wr_q   <= CMD_WRITE;
                addr_q <= CMD_ADDR;
                data_q <= CMD_DATA;
            end
            if (state_d != state_q) begin
                case (state_d)
                    A_SETUP, R_WAIT: begin
                        BUS_ADDR_OR_DATA <= 1'b1;
                        BUS_DATA_OUT     <= {{(DATA_W-ADDR_W){1'b0}}, cur_addr};
                    end
                    D_SETUP: begin
                        BUS_ADDR_OR_DATA <= 1'b0;
                        BUS_DATA_OUT     <= cur_data;
                    end
                    default: ;
                endcase
            end
            if (state_q == D_HOLD && state_d == DONE)
                RSP_DATA <= data_q;
            else if (state_q == R_WAIT && state_d == DONE)
                RSP_DATA <= BUS_DATA_IN;
        end
    end

    bus_strobe_gen #(
        .SETUP_W (SETUP_W),
        .PULSE_W (PULSE_W),
        .HOLD_W  (HOLD_W)
    ) u_strobe (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (sg_start),
        .bus_write  (BUS_WRITE),
        .stage_last (sg_last),
        .done       (sg_done)
    );

    assign CMD_READY = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign RSP_VALID = (state_q == DONE);

endmodule
